// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Register-file pending-write scoreboard. Tracks outstanding
//               writes per architectural register, detects read-after-write
//               hazards, forwards same-cycle writeback data and throttles
//               issue when a register's pending counter is saturated.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter int RF_DEPTH = 32,
    parameter int PEND_W   = 2,
    localparam int IDX_W   = $clog2(RF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    // issue side
    input  logic             iss_valid,
    input  logic             iss_dst_ready,
    output logic             iss_ready,
    input  logic [IDX_W-1:0] iss_rs1,
    input  logic [IDX_W-1:0] iss_rs2,
    input  logic             iss_rs1_en,
    input  logic             iss_rs2_en,
    input  logic [IDX_W-1:0] iss_rd,
    input  logic             iss_rd_en,
    // writeback side
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_rd,
    // hazard / forwarding
    output logic             fwd_rs1_rf,
    output logic             fwd_rs2_rf,
    output logic             stall_raw,
    // control / status
    input  logic             invalidate,
    output logic             busy,
    output logic             err_underflow
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] cnt_q [RF_DEPTH];
    logic [PEND_W-1:0] cnt_d [RF_DEPTH];
    logic              busy_q;
    logic              busy_d;
    logic              err_q;
    logic              err_d;

    logic [PEND_W-1:0] w_cnt_rs1;
    logic [PEND_W-1:0] w_cnt_rs2;
    logic [PEND_W-1:0] w_cnt_rd;
    logic [PEND_W-1:0] w_cnt_wb;
    logic              w_wb_ev;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_fwd1;
    logic              w_fwd2;
    logic              w_stall_raw;
    logic              w_stall_sat;
    logic              w_ready;
    logic              w_inc;

    assign w_cnt_rs1 = cnt_q[iss_rs1];
    assign w_cnt_rs2 = cnt_q[iss_rs2];
    assign w_cnt_rd  = cnt_q[iss_rd];
    assign w_cnt_wb  = cnt_q[wb_rd];

    // Register 0 is hardwired, so writebacks to it are not events at all.
    assign w_wb_ev = wb_valid && (wb_rd != '0);

    // Hazard, forwarding and readiness: purely combinational, zero latency.
    always_comb begin
        w_hit1      = iss_rs1_en && (iss_rs1 != '0) && (w_cnt_rs1 != '0);
        w_hit2      = iss_rs2_en && (iss_rs2 != '0) && (w_cnt_rs2 != '0);
        // Forward only when the retiring write is the last one outstanding.
        w_fwd1      = w_hit1 && (w_cnt_rs1 == CNT_ONE) && w_wb_ev && (wb_rd == iss_rs1);
        w_fwd2      = w_hit2 && (w_cnt_rs2 == CNT_ONE) && w_wb_ev && (wb_rd == iss_rs2);
        w_stall_raw = iss_valid && ((w_hit1 && !w_fwd1) || (w_hit2 && !w_fwd2));
        // A saturated counter may still accept an issue if a writeback frees a slot.
        w_stall_sat = iss_rd_en && (iss_rd != '0) && (w_cnt_rd == CNT_MAX)
                      && !(w_wb_ev && (wb_rd == iss_rd));
        w_ready     = iss_dst_ready && !w_stall_raw && !w_stall_sat;
        w_inc       = iss_valid && w_ready && iss_rd_en && (iss_rd != '0);
    end

    // Next-state of every pending counter plus the aggregate busy / error flags.
    always_comb begin
        busy_d = 1'b0;
        err_d  = err_q || (w_wb_ev && (w_cnt_wb == '0));
        for (int r = 0; r < RF_DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
            if (invalidate) begin
                cnt_d[r] = '0;
            end else if (w_inc && (iss_rd == IDX_W'(r))) begin
                // Simultaneous issue and writeback to the same register cancel out.
                if (!(w_wb_ev && (wb_rd == IDX_W'(r)))) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end
            end else if (w_wb_ev && (wb_rd == IDX_W'(r)) && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
        for (int r = 1; r < RF_DEPTH; r++) begin
            busy_d = busy_d | (|cnt_d[r]);
        end
    end

    // State registers; synchronous active-low reset dominates everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < RF_DEPTH; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < RF_DEPTH; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign iss_ready     = w_ready;
    assign fwd_rs1_rf    = w_fwd1;
    assign fwd_rs2_rf    = w_fwd2;
    assign stall_raw     = w_stall_raw;
    assign busy          = busy_q;
    assign err_underflow = err_q;

endmodule
`default_nettype wire
